// File: rtl/apb_requester_if.sv
// Command, response and APB bus bundle for the APB requester.
// master = requester side, slave = the command source / APB completer side.
interface apb_requester_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
);
    logic              cmd_valid;
    logic              cmd_ready;
    logic [ADDR_W-1:0] cmd_addr;
    logic [DATA_W-1:0] cmd_wdata;
    logic              cmd_write;

    logic              rsp_valid;
    logic              rsp_ready;
    logic [DATA_W-1:0] rsp_rdata;
    logic              rsp_slverr;
    logic              rsp_timeout;

    logic [ADDR_W-1:0] paddr;
    logic [DATA_W-1:0] pwdata;
    logic              pwrite;
    logic              psel;
    logic              penable;
    logic [DATA_W-1:0] prdata;
    logic              pready;
    logic              pslverr;

    modport master (
        input  cmd_valid, cmd_addr, cmd_wdata, cmd_write,
        output cmd_ready,
        output rsp_valid, rsp_rdata, rsp_slverr, rsp_timeout,
        input  rsp_ready,
        output paddr, pwdata, pwrite, psel, penable,
        input  prdata, pready, pslverr
    );

    modport slave (
        output cmd_valid, cmd_addr, cmd_wdata, cmd_write,
        input  cmd_ready,
        input  rsp_valid, rsp_rdata, rsp_slverr, rsp_timeout,
        output rsp_ready,
        input  paddr, pwdata, pwrite, psel, penable,
        output prdata, pready, pslverr
    );
endinterface

// File: rtl/apb_requester.sv
// APB initiator: one SETUP/ACCESS transfer per accepted command, response
// returned on a valid/ready port, watchdog ends transfers that never see pready.
module apb_requester #(
    parameter int ADDR_W  = 32,
    parameter int DATA_W  = 32,
    parameter int TIMEOUT = 16
) (
    input logic            clk_i,
    input logic            rst_ni,
    apb_requester_if.master bus
);
    localparam int CNT_W     = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
    localparam int TO_LAST_I = (TIMEOUT > 0) ? TIMEOUT - 1 : 0;
    localparam logic [CNT_W-1:0] TO_LAST = TO_LAST_I[CNT_W-1:0];
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    typedef enum logic [1:0] {IDLE, SETUP, ACCESS, RESP} state_e;

    state_e            state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              cmd_ready_q, cmd_ready_d;
    logic [ADDR_W-1:0] paddr_q, paddr_d;
    logic [DATA_W-1:0] pwdata_q, pwdata_d;
    logic              pwrite_q, pwrite_d;
    logic              psel_q, psel_d;
    logic              penable_q, penable_d;
    logic              rsp_valid_q, rsp_valid_d;
    logic [DATA_W-1:0] rsp_rdata_q, rsp_rdata_d;
    logic              rsp_slverr_q, rsp_slverr_d;
    logic              rsp_timeout_q, rsp_timeout_d;
    logic              finish;

    always_comb begin
        state_d       = state_q;
        cnt_d         = cnt_q;
        cmd_ready_d   = cmd_ready_q;
        paddr_d       = paddr_q;
        pwdata_d      = pwdata_q;
        pwrite_d      = pwrite_q;
        psel_d        = psel_q;
        penable_d     = penable_q;
        rsp_valid_d   = rsp_valid_q;
        rsp_rdata_d   = rsp_rdata_q;
        rsp_slverr_d  = rsp_slverr_q;
        rsp_timeout_d = rsp_timeout_q;
        finish        = 1'b0;

        case (state_q)
            IDLE: begin
                cmd_ready_d = 1'b1;
                if (bus.cmd_valid && cmd_ready_q) begin
                    paddr_d = bus.cmd_addr;
                    // pwdata keeps its previous value across reads
                    if (bus.cmd_write) pwdata_d = bus.cmd_wdata;
                    pwrite_d    = bus.cmd_write;
                    psel_d      = 1'b1;
                    penable_d   = 1'b0;
                    cmd_ready_d = 1'b0;
                    state_d     = SETUP;
                end
            end
            SETUP: begin
                penable_d = 1'b1;
                cnt_d     = '0;
                state_d   = ACCESS;
            end
            ACCESS: begin
                if (bus.pready) begin
                    rsp_rdata_d   = pwrite_q ? '0 : bus.prdata;
                    rsp_slverr_d  = bus.pslverr;
                    rsp_timeout_d = 1'b0;
                    finish        = 1'b1;
                end else begin
                    if (TIMEOUT != 0 && cnt_q == TO_LAST) begin
                        rsp_rdata_d   = '0;
                        rsp_slverr_d  = 1'b1;
                        rsp_timeout_d = 1'b1;
                        finish        = 1'b1;
                    end
                    if (cnt_q != CNT_MAX) cnt_d = cnt_q + 1'b1;
                end
                if (finish) begin
                    psel_d      = 1'b0;
                    penable_d   = 1'b0;
                    rsp_valid_d = 1'b1;
                    state_d     = RESP;
                end
            end
            RESP: begin
                if (bus.rsp_ready) begin
                    rsp_valid_d = 1'b0;
                    state_d     = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            state_q       <= IDLE;
            cnt_q         <= '0;
            cmd_ready_q   <= 1'b0;
            paddr_q       <= '0;
            pwdata_q      <= '0;
            pwrite_q      <= 1'b0;
            psel_q        <= 1'b0;
            penable_q     <= 1'b0;
            rsp_valid_q   <= 1'b0;
            rsp_rdata_q   <= '0;
            rsp_slverr_q  <= 1'b0;
            rsp_timeout_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            cnt_q         <= cnt_d;
            cmd_ready_q   <= cmd_ready_d;
            paddr_q       <= paddr_d;
            pwdata_q      <= pwdata_d;
            pwrite_q      <= pwrite_d;
            psel_q        <= psel_d;
            penable_q     <= penable_d;
            rsp_valid_q   <= rsp_valid_d;
            rsp_rdata_q   <= rsp_rdata_d;
            rsp_slverr_q  <= rsp_slverr_d;
            rsp_timeout_q <= rsp_timeout_d;
        end
    end

    assign bus.cmd_ready   = cmd_ready_q;
    assign bus.paddr       = paddr_q;
    assign bus.pwdata      = pwdata_q;
    assign bus.pwrite      = pwrite_q;
    assign bus.psel        = psel_q;
    assign bus.penable     = penable_q;
    assign bus.rsp_valid   = rsp_valid_q;
    assign bus.rsp_rdata   = rsp_rdata_q;
    assign bus.rsp_slverr  = rsp_slverr_q;
    assign bus.rsp_timeout = rsp_timeout_q;
endmodule

// File: tb/tb_apb_requester.sv
// Self-checking bench for apb_requester: vector table of transfers with a
// response scoreboard, plus backpressure and mid-transfer reset sequences.
module tb_apb_requester;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   tests = 0;
    int   fails = 0;

    always #5 clk = ~clk;

    apb_requester_if #(.ADDR_W(32), .DATA_W(32)) bus ();

    apb_requester #(.ADDR_W(32), .DATA_W(32), .TIMEOUT(16)) dut (
        .clk_i (clk),
        .rst_ni(rst_n),
        .bus   (bus)
    );

    typedef struct {
        logic [31:0] addr;
        logic [31:0] wdata;
        logic        wr;
        int          nwait;
        logic        slv;
        logic [31:0] rd;
        logic [31:0] e_rdata;
        logic        e_slv;
        logic        e_to;
        int          e_lat;
        int          e_acc;
    } vec_t;

    typedef struct {
        logic [31:0] rdata;
        logic        slv;
        logic        to;
    } exp_t;

    vec_t vecs[7];
    exp_t sb[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic check_rsp();
        exp_t e;
        if (sb.size() == 0) begin
            tests++;
            fails++;
            $display("FAIL rsp_scoreboard: got response with empty queue");
        end else begin
            e = sb.pop_front();
            chk("rsp_valid", 32'(bus.rsp_valid), 32'd1);
            chk("rsp_rdata", bus.rsp_rdata, e.rdata);
            chk("rsp_slverr", 32'(bus.rsp_slverr), 32'(e.slv));
            chk("rsp_timeout", 32'(bus.rsp_timeout), 32'(e.to));
        end
    endtask

    // Called at a negedge; returns at the negedge of the SETUP cycle.
    task automatic accept_cmd(input logic [31:0] a, input logic [31:0] w, input logic wr);
        int n = 0;
        bus.cmd_addr  = a;
        bus.cmd_wdata = w;
        bus.cmd_write = wr;
        bus.cmd_valid = 1'b1;
        while (!bus.cmd_ready && n < 20) begin
            @(negedge clk);
            n++;
        end
        chk("cmd_ready_wait", 32'(n < 20), 32'd1);
        @(posedge clk);
        @(negedge clk);
        bus.cmd_valid = 1'b0;
    endtask

    // Acts as the APB completer from the SETUP negedge until rsp_valid.
    task automatic play_access(input logic [31:0] addr, input logic [31:0] wdata, input logic wr,
                               input int nwait, input logic slv, input logic [31:0] rd,
                               output int lat, output int acc, output bit bus_ok, output bit proto_ok);
        bit done = 0;
        lat      = 1;
        acc      = 0;
        bus_ok   = 1;
        proto_ok = (bus.psel === 1'b1 && bus.penable === 1'b0);
        for (int c = 0; c < 64 && !done; c++) begin
            if (c > 0) begin
                @(negedge clk);
                lat++;
            end
            if (bus.rsp_valid) begin
                done = 1;
                if (bus.psel || bus.penable) proto_ok = 0;
            end else begin
                if (bus.penable && !bus.psel) proto_ok = 0;
                if (c == 1 && !bus.penable) proto_ok = 0;
                if (!bus.psel) proto_ok = 0;
                if (bus.paddr !== addr || bus.pwrite !== wr || (wr && bus.pwdata !== wdata)) bus_ok = 0;
                if (bus.penable) begin
                    acc++;
                    bus.pready  = (acc > nwait);
                    bus.pslverr = (acc > nwait) ? slv : 1'b1;
                    bus.prdata  = (acc > nwait) ? rd : 32'h0BAD_0BAD;
                end else begin
                    bus.pready  = 1'b0;
                    bus.pslverr = 1'b0;
                end
            end
        end
        bus.pready  = 1'b0;
        bus.pslverr = 1'b0;
        if (!done) lat = -1;
    endtask

    task automatic run_vec(input vec_t v);
        int lat, acc;
        bit bok, pok;
        sb.push_back('{v.e_rdata, v.e_slv, v.e_to});
        accept_cmd(v.addr, v.wdata, v.wr);
        play_access(v.addr, v.wdata, v.wr, v.nwait, v.slv, v.rd, lat, acc, bok, pok);
        chk("latency", 32'(lat), 32'(v.e_lat));
        chk("access_cycles", 32'(acc), 32'(v.e_acc));
        chk("bus_stable", 32'(bok), 32'd1);
        chk("apb_protocol", 32'(pok), 32'd1);
        check_rsp();
        bus.rsp_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        bus.rsp_ready = 1'b0;
        chk("rsp_valid_cleared", 32'(bus.rsp_valid), 32'd0);
    endtask

    initial begin
        int lat, acc, n;
        bit bok, pok;

        //            addr          wdata         wr  nw   slv  rd            e_rdata       e_slv e_to lat acc
        vecs[0] = '{32'h0000_0004, 32'hA5A5_1234, 1'b1, 0,   1'b0, 32'h0,         32'h0,         1'b0, 1'b0, 3,  1};
        vecs[1] = '{32'h0000_0008, 32'h0,         1'b0, 3,   1'b0, 32'hDEAD_BEEF, 32'hDEAD_BEEF, 1'b0, 1'b0, 6,  4};
        vecs[2] = '{32'h0000_000C, 32'h0,         1'b0, 0,   1'b1, 32'h1234_5678, 32'h1234_5678, 1'b1, 1'b0, 3,  1};
        vecs[3] = '{32'h0000_0010, 32'h0,         1'b0, 2,   1'b0, 32'hCAFE_F00D, 32'hCAFE_F00D, 1'b0, 1'b0, 5,  3};
        vecs[4] = '{32'h0000_0020, 32'h1357_9BDF, 1'b1, 255, 1'b0, 32'h0,         32'h0,         1'b1, 1'b1, 18, 16};
        vecs[5] = '{32'h0000_0024, 32'h0,         1'b0, 15,  1'b0, 32'h600D_F00D, 32'h600D_F00D, 1'b0, 1'b0, 18, 16};
        vecs[6] = '{32'h0000_0030, 32'h5555_AAAA, 1'b1, 1,   1'b1, 32'hFFFF_FFFF, 32'h0,         1'b1, 1'b0, 4,  2};

        bus.cmd_valid = 1'b0;
        bus.cmd_addr  = '0;
        bus.cmd_wdata = '0;
        bus.cmd_write = 1'b0;
        bus.rsp_ready = 1'b0;
        bus.prdata    = '0;
        bus.pready    = 1'b0;
        bus.pslverr   = 1'b0;

        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("reset_ctrl", {25'd0, bus.psel, bus.penable, bus.pwrite, bus.rsp_valid,
                           bus.rsp_slverr, bus.rsp_timeout, bus.cmd_ready}, 32'd0);
        chk("reset_paddr", bus.paddr, 32'd0);
        chk("reset_pwdata", bus.pwdata, 32'd0);
        chk("reset_rdata", bus.rsp_rdata, 32'd0);
        rst_n = 1'b1;
        @(negedge clk);
        chk("cmd_ready_after_reset", 32'(bus.cmd_ready), 32'd1);

        for (int i = 0; i < 7; i++) run_vec(vecs[i]);

        // Response backpressure with a second command waiting
        sb.push_back('{32'h0, 1'b0, 1'b0});
        accept_cmd(32'h0000_0040, 32'h1111_2222, 1'b1);
        play_access(32'h0000_0040, 32'h1111_2222, 1'b1, 0, 1'b0, 32'h0, lat, acc, bok, pok);
        chk("bp_latency", 32'(lat), 32'd3);
        bus.cmd_addr  = 32'h0000_0044;
        bus.cmd_wdata = 32'h0;
        bus.cmd_write = 1'b0;
        bus.cmd_valid = 1'b1;
        sb.push_back('{32'h7777_8888, 1'b0, 1'b0});
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("bp_hold", {27'd0, bus.rsp_valid, bus.rsp_slverr, bus.rsp_timeout,
                            bus.cmd_ready, bus.psel}, 32'b10000);
            chk("bp_rdata", bus.rsp_rdata, 32'h0);
        end
        check_rsp();
        bus.rsp_ready = 1'b1;
        @(posedge clk);
        #1 bus.rsp_ready = 1'b0;
        n = 0;
        while (n < 10) begin
            @(negedge clk);
            n++;
            if (bus.psel) break;
        end
        chk("bp_restart_delay", 32'(n), 32'd3);
        bus.cmd_valid = 1'b0;
        play_access(32'h0000_0044, 32'h0, 1'b0, 0, 1'b0, 32'h7777_8888, lat, acc, bok, pok);
        chk("bp2_latency", 32'(lat), 32'd3);
        chk("bp2_bus_stable", 32'(bok), 32'd1);
        check_rsp();
        bus.rsp_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        bus.rsp_ready = 1'b0;

        // Reset during an ACCESS wait state abandons the transfer
        accept_cmd(32'h0000_0050, 32'h0, 1'b0);
        @(negedge clk);
        @(negedge clk);
        chk("pre_reset_access", {30'd0, bus.psel, bus.penable}, 32'b11);
        rst_n = 1'b0;
        @(negedge clk);
        chk("mid_reset_outputs", {28'd0, bus.psel, bus.penable, bus.rsp_valid, bus.cmd_ready}, 32'd0);
        rst_n = 1'b1;
        @(negedge clk);
        chk("post_reset_ready", {29'd0, bus.cmd_ready, bus.psel, bus.rsp_valid}, 32'b100);
        run_vec(vecs[1]);

        chk("scoreboard_empty", 32'(sb.size()), 32'd0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1, "global timeout");
    end
endmodule
